// File: rtl/agm_pkg.sv
// rtl/agm_pkg.sv - shared fetch-stage types and constants for the AGM-V fetch unit
package agm_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_VALID,
        S_HALT
    } fetch_state_e;

    localparam int CMD_W      = 24;
    localparam int OPCODE_MSB = 23;
    localparam int OPCODE_LSB = 16;

    localparam logic [1:0] IDX_B0 = 2'd0;
    localparam logic [1:0] IDX_B1 = 2'd1;
    localparam logic [1:0] IDX_B2 = 2'd2;

endpackage

// File: rtl/agm_fetch_assembler.sv
// rtl/agm_fetch_assembler.sv - captures three program bytes and publishes the 24-bit command word
module agm_fetch_assembler
    import agm_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cap_en,
    input  logic [1:0]            idx,
    input  logic [DATA_W-1:0]     rdata,
    output logic [3*DATA_W-1:0]   cmd_word,
    output logic                  ir_load
);

    logic [DATA_W-1:0]   b0_q, b0_d;
    logic [DATA_W-1:0]   b1_q, b1_d;
    logic [3*DATA_W-1:0] word_q, word_d;

    always_comb begin
        b0_d    = b0_q;
        b1_d    = b1_q;
        word_d  = word_q;
        ir_load = 1'b0;
        if (cap_en) begin
            case (idx)
                IDX_B0: b0_d = rdata;
                IDX_B1: b1_d = rdata;
                IDX_B2: begin
                    // byte0 sits at the lowest address, so it lands in the opcode field
                    word_d  = {b0_q, b1_q, rdata};
                    ir_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b0_q   <= '0;
            b1_q   <= '0;
            word_q <= '0;
        end else begin
            b0_q   <= b0_d;
            b1_q   <= b1_d;
            word_q <= word_d;
        end
    end

    assign cmd_word = word_q;

endmodule

// File: rtl/agm_fetch_unit.sv
// rtl/agm_fetch_unit.sv - AGM-V fetch FSM and PC owner; FETCH_WRAP_TRAP_EN traps instructions straddling the end of memory
module agm_fetch_unit
    import agm_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter int                MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CMD_W-1:0]  cmd_word,
    output logic [7:0]        opcode,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              ir_load,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_err
);

    localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        lat_q, lat_d;
    logic              cap_en;
`ifdef FETCH_WRAP_TRAP_EN
    logic              err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        cap_en    = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        cmd_valid = 1'b0;
`ifdef FETCH_WRAP_TRAP_EN
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_REQ;
            end
            S_REQ: begin
                mem_rd   = 1'b1;
                mem_addr = pc_q;
                lat_d    = 2'd0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    cap_en = 1'b1;
                    pc_d   = pc_q + ADDR_W'(1);
                    if (idx_q == IDX_B2) begin
                        idx_d   = IDX_B0;
                        state_d = S_VALID;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_REQ;
                    end
`ifdef FETCH_WRAP_TRAP_EN
                    // wrapping before the last byte means the word spans the end of memory
                    if ((&pc_q) && (idx_q != IDX_B2)) begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
`endif
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_VALID: begin
                cmd_valid = 1'b1;
                if (cmd_ready) state_d = S_REQ;
            end
`ifdef FETCH_WRAP_TRAP_EN
            S_HALT: ;
`endif
            default: state_d = S_IDLE;
        endcase

        // a redirect overrides any capture or handshake decided above
        if (jmp_valid) begin
            pc_d = jmp_addr;
            if (state_q != S_IDLE) begin
                cap_en  = 1'b0;
                idx_d   = IDX_B0;
                lat_d   = 2'd0;
                state_d = S_REQ;
`ifdef FETCH_WRAP_TRAP_EN
                err_d   = 1'b0;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            idx_q   <= IDX_B0;
            lat_q   <= 2'd0;
`ifdef FETCH_WRAP_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
`ifdef FETCH_WRAP_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    agm_fetch_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (cap_en),
        .idx      (idx_q),
        .rdata    (mem_rdata),
        .cmd_word (cmd_word),
        .ir_load  (ir_load)
    );

    assign opcode = cmd_word[OPCODE_MSB:OPCODE_LSB];
    assign pc_out = pc_q;
`ifdef FETCH_WRAP_TRAP_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_agm_fetch_unit.sv
// tb/tb_agm_fetch_unit.sv - self-checking bench for agm_fetch_unit (MEM_LAT 1 and 3 instances)
module tb_agm_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        run = 1'b0, cmd_ready = 1'b0, jmp_valid = 1'b0;
    logic [7:0]  jmp_addr = 8'h00;
    logic [7:0]  mem_addr, mem_rdata, opcode, pc_out;
    logic        mem_rd, cmd_valid, ir_load, fetch_err;
    logic [23:0] cmd_word;

    logic        run_3 = 1'b0, cmd_ready_3 = 1'b0, jmp_valid_3 = 1'b0;
    logic [7:0]  jmp_addr_3 = 8'h00;
    logic [7:0]  mem_addr_3, mem_rdata_3, opcode_3, pc_out_3;
    logic        mem_rd_3, cmd_valid_3, ir_load_3, fetch_err_3;
    logic [23:0] cmd_word_3;

    logic [7:0]  mem [256];
    logic [7:0]  pipe1;
    logic [7:0]  pipe3 [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    agm_fetch_unit #(.MEM_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .cmd_word(cmd_word), .opcode(opcode), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .ir_load(ir_load), .jmp_valid(jmp_valid), .jmp_addr(jmp_addr),
        .pc_out(pc_out), .fetch_err(fetch_err)
    );

    agm_fetch_unit #(.MEM_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .run(run_3), .mem_addr(mem_addr_3), .mem_rd(mem_rd_3),
        .mem_rdata(mem_rdata_3), .cmd_word(cmd_word_3), .opcode(opcode_3), .cmd_valid(cmd_valid_3),
        .cmd_ready(cmd_ready_3), .ir_load(ir_load_3), .jmp_valid(jmp_valid_3), .jmp_addr(jmp_addr_3),
        .pc_out(pc_out_3), .fetch_err(fetch_err_3)
    );

    // program memory: data appears MEM_LAT cycles after the read strobe, zero otherwise
    always @(posedge clk) begin
        pipe1    <= mem_rd ? mem[mem_addr] : 8'h00;
        pipe3[0] <= mem_rd_3 ? mem[mem_addr_3] : 8'h00;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_rdata   = pipe1;
    assign mem_rdata_3 = pipe3[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rd(input bit sel);
        int c = 0;
        while (!(sel ? mem_rd_3 : mem_rd) && c < 40) begin
            @(negedge clk);
            c++;
        end
        if (c >= 40) check("wait_rd_timeout", 0, 1);
    endtask

    task automatic wait_valid_or_err();
        int c = 0;
        while (!cmd_valid && !fetch_err && c < 60) begin
            @(negedge clk);
            c++;
        end
        if (c >= 60) check("wait_valid_timeout", 0, 1);
    endtask

    task automatic measure(input bit sel, output int lat, output int rds, output logic ir_prev);
        lat = 0;
        rds = 1;
        ir_prev = 1'b0;
        while (lat < 60) begin
            ir_prev = sel ? ir_load_3 : ir_load;
            @(negedge clk);
            lat++;
            if (sel ? mem_rd_3 : mem_rd) rds++;
            if (sel ? cmd_valid_3 : cmd_valid) break;
        end
    endtask

    initial begin
        int          lat, rds, words;
        logic        ir_prev, stable;
        logic [23:0] held, exp_word;
        logic [7:0]  model_pc, a1, a2;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'hA1; mem[8'h01] = 8'h12; mem[8'h02] = 8'h34;
        mem[8'h40] = 8'h55; mem[8'h41] = 8'h66; mem[8'h42] = 8'h77;
        mem[8'hFE] = 8'hC3; mem[8'hFF] = 8'hD4;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_word", cmd_word, 0);
        check("rst_ir_load", ir_load, 0);
        check("rst_pc_out", pc_out, 8'h00);
        check("rst_fetch_err", fetch_err, 0);

        @(negedge clk);
        run = 1'b1;
        wait_rd(1'b0);
        check("first_addr", mem_addr, 8'h00);
        measure(1'b0, lat, rds, ir_prev);
        check("lat1_cycles", lat, 6);
        check("lat1_rd_count", rds, 3);
        check("word0", cmd_word, 24'hA11234);
        check("opcode0", opcode, 8'hA1);
        check("ir_load_before_valid", ir_prev, 1);
        check("pc_after_word0", pc_out, 8'h03);

        held = cmd_word;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (cmd_word !== held || mem_rd || !cmd_valid) stable = 1'b0;
        end
        check("hold_stable_no_rd", stable, 1);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("after_accept_rd", mem_rd, 1);
        check("after_accept_addr", mem_addr, 8'h03);

        @(negedge clk);
        @(negedge clk);
        check("byte1_addr", mem_addr, 8'h04);
        @(negedge clk);
        jmp_valid = 1'b1;
        jmp_addr  = 8'h40;
        @(negedge clk);
        jmp_valid = 1'b0;
        check("jmp_rd", mem_rd, 1);
        check("jmp_addr_out", mem_addr, 8'h40);
        check("jmp_no_valid", cmd_valid, 0);
        wait_valid_or_err();
        check("jmp_word", cmd_word, 24'h556677);
        check("jmp_pc", pc_out, 8'h43);

        run_3 = 1'b1;
        wait_rd(1'b1);
        measure(1'b1, lat, rds, ir_prev);
        check("lat3_cycles", lat, 12);
        check("lat3_rd_count", rds, 3);
        check("lat3_word", cmd_word_3, 24'hA11234);

        jmp_valid = 1'b1;
        jmp_addr  = 8'hFE;
        @(negedge clk);
        jmp_valid = 1'b0;
        check("wrap_start_addr", mem_addr, 8'hFE);
        wait_valid_or_err();
`ifdef FETCH_WRAP_TRAP_EN
        check("trap_err", fetch_err, 1);
        check("trap_no_valid", cmd_valid, 0);
        stable = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (cmd_valid || mem_rd || !fetch_err) stable = 1'b0;
        end
        check("trap_halted", stable, 1);
        jmp_valid = 1'b1;
        jmp_addr  = 8'h00;
        @(negedge clk);
        jmp_valid = 1'b0;
        check("trap_cleared", fetch_err, 0);
        check("trap_exit_addr", mem_addr, 8'h00);
`else
        check("wrap_word", cmd_word, 24'hC3D4A1);
        check("wrap_err", fetch_err, 0);
        check("wrap_pc", pc_out, 8'h01);
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("wrap_next_addr", mem_addr, 8'h01);
`endif

        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rd", mem_rd, 0);
        check("async_rst_valid", cmd_valid, 0);
        check("async_rst_pc", pc_out, 8'h00);
        check("async_rst_valid3", cmd_valid_3, 0);
        check("async_rst_word3", cmd_word_3, 0);
        @(negedge clk);
        rst   = 1'b0;
        run_3 = 1'b0;

        model_pc = 8'h00;
        words = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            cmd_ready = ($urandom_range(0, 1) == 1);
            jmp_valid = ($urandom_range(0, 19) == 0);
            jmp_addr  = 8'($urandom);
            if (cmd_valid && cmd_ready) begin
                a1 = model_pc + 8'd1;
                a2 = model_pc + 8'd2;
                exp_word = {mem[model_pc], mem[a1], mem[a2]};
                check("rand_word", cmd_word, exp_word);
`ifdef FETCH_WRAP_TRAP_EN
                check("rand_no_straddle", (model_pc >= 8'hFE), 0);
`endif
                model_pc = model_pc + 8'd3;
                words++;
            end
            if (jmp_valid) model_pc = jmp_addr;
        end
        jmp_valid = 1'b0;
        cmd_ready = 1'b0;
        check("rand_words_seen", (words > 20), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
